// File: rtl/praxos_irq_in.sv
// praxos_irq_in: interrupt input conditioner for the Praxos irq_in port.
// Sync, optional deglitch, level/edge sticky pending, mask, registered out.
module praxos_irq_in #(
  parameter int          NUM_SRC     = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EDGE_SEL    = 32'h0000_0000,
  parameter int          FILTER_LEN  = 0,
  parameter logic [4:0]  ACK_ADDR    = 5'd1,
  parameter logic [4:0]  MASK_ADDR   = 5'd2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src_in,
  input  logic [4:0]         praxos_port_addr,
  input  logic               praxos_port_wr,
  input  logic [31:0]        praxos_port_wr_data,
  output logic [31:0]        irq_in_out,
  output logic               irq_any
);

  if (ACK_ADDR == MASK_ADDR) begin : g_err_same_addr
    $error("praxos_irq_in: ACK_ADDR must differ from MASK_ADDR");
  end
  if (ACK_ADDR >= 5'd16) begin : g_err_ack_gp
    $error("praxos_irq_in: ACK_ADDR collides with GP registers");
  end
  if (MASK_ADDR >= 5'd16) begin : g_err_mask_gp
    $error("praxos_irq_in: MASK_ADDR collides with GP registers");
  end
  if (FILTER_LEN > 255 || FILTER_LEN < 0) begin : g_err_filt
    $error("praxos_irq_in: FILTER_LEN must be 0..255");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("praxos_irq_in: SYNC_STAGES must be at least 2");
  end
  if (NUM_SRC < 1 || NUM_SRC > 32) begin : g_err_nsrc
    $error("praxos_irq_in: NUM_SRC must be 1..32");
  end

  localparam logic [NUM_SRC-1:0] EDGE_M =
    EDGE_SEL[NUM_SRC-1:0];
  localparam logic [31:0] VALID =
    (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                    : ((32'd1 << NUM_SRC) - 32'd1);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] f;
  logic [NUM_SRC-1:0] f_d_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] ack_clr;
  logic [31:0]        mask_q;
  logic               ack_hit;
  logic               mask_hit;

  // Metastability chain per source; s is the settled sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync_q[k] <= '0;
    end else begin
      sync_q[0] <= irq_src_in;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  if (FILTER_LEN == 0) begin : g_nofilt
    assign f = s;
  end else begin : g_filt
    localparam logic [7:0] LAST = 8'(FILTER_LEN - 1);

    logic [7:0]         cnt_q [NUM_SRC];
    logic [NUM_SRC-1:0] f_q;

    // Accept a new level only after it has held FILTER_LEN cycles.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        f_q <= '0;
        for (int i = 0; i < NUM_SRC; i++)
          cnt_q[i] <= '0;
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          unique case (1'b1)
            (s[i] == f_q[i]): begin
              cnt_q[i] <= '0;
            end
            (s[i] != f_q[i]) && (cnt_q[i] == LAST): begin
              f_q[i]   <= s[i];
              cnt_q[i] <= '0;
            end
            default: begin
              cnt_q[i] <= cnt_q[i] + 8'd1;
            end
          endcase
        end
      end
    end

    assign f = f_q;
  end

  assign ack_hit  = praxos_port_wr &&
                    (praxos_port_addr == ACK_ADDR);
  assign mask_hit = praxos_port_wr &&
                    (praxos_port_addr == MASK_ADDR);

  assign ack_clr = ack_hit
                 ? (praxos_port_wr_data[NUM_SRC-1:0] & EDGE_M)
                 : '0;

  assign rise = f & ~f_d_q & EDGE_M;

  // Level bits follow f; edge bits are sticky and a new edge
  // beats a simultaneous acknowledge.
  assign pend_nxt = (f & ~EDGE_M)
                  | rise
                  | (pend_q & EDGE_M & ~ack_clr);

  // Edge history and pending state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_d_q  <= '0;
      pend_q <= '0;
    end else begin
      f_d_q  <= f;
      pend_q <= pend_nxt;
    end
  end

  // Mask register, loaded by Praxos port writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (mask_hit) begin
      mask_q <= praxos_port_wr_data;
    end
  end

  // Registered, masked vector towards the control block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_in_out <= '0;
    end else begin
      irq_in_out <= 32'(pend_q) & mask_q & VALID;
    end
  end

  assign irq_any = |irq_in_out;

endmodule

// File: tb/tb_praxos_irq_in.sv
// tb_praxos_irq_in: edge-indexed behavioural model plus directed checks.
// Instance A: level/edge mix, no filter. Instance B: 8 sources, filter 4.
module tb_praxos_irq_in;

  localparam int          NE     = 2048;
  localparam int          SYNC   = 2;
  localparam logic [31:0] EDGE_A = 32'h0000_0021;
  localparam logic [4:0]  ACK    = 5'd1;
  localparam logic [4:0]  MSK    = 5'd2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] src_a = '0;
  logic [7:0]  src_b = '0;
  logic [4:0]  addr  = '0;
  logic        wr    = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] out_a, out_b;
  logic        any_a, any_b;

  int checks   = 0;
  int failures = 0;
  int n        = -1;

  praxos_irq_in #(
    .EDGE_SEL(EDGE_A)
  ) dut_a (
    .clk                 (clk),
    .rst_n               (rst_n),
    .irq_src_in          (src_a),
    .praxos_port_addr    (addr),
    .praxos_port_wr      (wr),
    .praxos_port_wr_data (wdata),
    .irq_in_out          (out_a),
    .irq_any             (any_a)
  );

  praxos_irq_in #(
    .NUM_SRC    (8),
    .FILTER_LEN (4)
  ) dut_b (
    .clk                 (clk),
    .rst_n               (rst_n),
    .irq_src_in          (src_b),
    .praxos_port_addr    (addr),
    .praxos_port_wr      (wr),
    .praxos_port_wr_data (wdata),
    .irq_in_out          (out_b),
    .irq_any             (any_b)
  );

  always #5 clk = ~clk;

  int          m_fl  [2] = '{0, 4};
  logic [31:0] m_edg [2] = '{32'h0000_0021, 32'h0};
  logic [31:0] m_vld [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};

  bit          h_rst [NE];
  logic [31:0] h_src [2][NE];
  logic [31:0] h_ack [NE];
  bit          h_mw  [NE];
  logic [31:0] h_md  [NE];
  logic [31:0] m_s   [2][NE];
  logic [31:0] m_f   [2][NE];
  logic [31:0] m_p   [2][NE];
  logic [31:0] m_o   [2][NE];
  logic [31:0] m_mask[NE];

  function automatic bit rs(input int k);
    return (k < 0) ? 1'b1 : h_rst[k];
  endfunction
  function automatic logic [31:0] sv(input int i, input int k);
    return (k < 0) ? 32'h0 : m_s[i][k];
  endfunction
  function automatic logic [31:0] fv(input int i, input int k);
    return (k < 0) ? 32'h0 : m_f[i][k];
  endfunction
  function automatic logic [31:0] pv(input int i, input int k);
    return (k < 0) ? 32'h0 : m_p[i][k];
  endfunction
  function automatic logic [31:0] mv(input int k);
    return (k < 0) ? 32'h0 : m_mask[k];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h want=%h", nm, n, act, exp);
    end
  endtask

  // Values after edge e, derived from the recorded inputs.
  task automatic model_step(input int e);
    bit anyrst;
    if (rs(e)) m_mask[e] = '0;
    else if (h_mw[e]) m_mask[e] = h_md[e];
    else m_mask[e] = mv(e - 1);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] s, f, a1, a0, fc, fd, eg;
      anyrst = 1'b0;
      for (int k = e - SYNC + 1; k <= e; k++)
        if (rs(k)) anyrst = 1'b1;
      s = anyrst ? 32'h0 : h_src[i][e-SYNC+1];
      m_s[i][e] = s;
      if (m_fl[i] == 0) begin
        f = s;
      end else if (rs(e)) begin
        f = '0;
      end else begin
        a1 = '1;
        a0 = '1;
        for (int k = e - m_fl[i]; k < e; k++) begin
          a1 = a1 & sv(i, k);
          a0 = a0 & ~sv(i, k);
        end
        f = (fv(i, e - 1) | a1) & ~a0;
      end
      m_f[i][e] = f;
      eg = m_edg[i];
      fc = fv(i, e - 1);
      fd = rs(e - 1) ? 32'h0 : fv(i, e - 2);
      if (rs(e)) begin
        m_p[i][e] = '0;
        m_o[i][e] = '0;
      end else begin
        m_p[i][e] = (fc & ~eg) | (fc & ~fd & eg)
                  | (pv(i, e - 1) & eg & ~h_ack[e]);
        m_o[i][e] = pv(i, e - 1) & mv(e - 1) & m_vld[i];
      end
    end
  endtask

  // Per-edge compare against the model.
  always @(posedge clk) begin
    n = n + 1;
    if (n >= NE) begin
      $display("FAIL edge_budget n=%0d", n);
      $fatal(1, "edge budget exceeded");
    end
    h_rst[n]    = !rst_n;
    h_src[0][n] = src_a;
    h_src[1][n] = 32'(src_b);
    h_ack[n]    = (wr && addr == ACK) ? wdata : 32'h0;
    h_mw[n]     = wr && (addr == MSK);
    h_md[n]     = wdata;
    model_step(n);
    #1;
    chk("model_out_a", out_a, m_o[0][n]);
    chk("model_out_b", out_b, m_o[1][n]);
    chk("model_any_a", 32'(any_a), 32'(|m_o[0][n]));
    chk("model_any_b", 32'(any_b), 32'(|m_o[1][n]));
  end

  task automatic to_edge(input int e);
    while (n < e) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus(input logic [4:0] a, input logic [31:0] d,
                     output int t);
    @(negedge clk);
    t     = n;
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c;
    src_a = '1;
    src_b = '1;
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("rst_out_a", out_a, 32'h0);
      chk("rst_any_a", 32'(any_a), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #2;
      chk("nomask_out_a", out_a, 32'h0);
      chk("nomask_out_b", out_b, 32'h0);
    end
    @(negedge clk);
    src_a = '0;
    src_b = '0;
    repeat (10) @(negedge clk);
    bus(ACK, 32'hFFFF_FFFF, t);
    repeat (4) @(negedge clk);

    bus(MSK, 32'h8, t);
    repeat (3) @(negedge clk);
    t = n;
    src_a[3] = 1'b1;
    to_edge(t + 3);
    chk("lvl_before", out_a, 32'h0);
    to_edge(t + 4);
    chk("lvl_rise", out_a, 32'h8);
    to_edge(t + 10);
    @(negedge clk);
    c = n;
    src_a[3] = 1'b0;
    to_edge(c + 3);
    chk("lvl_hold", out_a, 32'h8);
    to_edge(c + 4);
    chk("lvl_fall", out_a, 32'h0);

    bus(MSK, 32'h20, t);
    @(negedge clk);
    t = n;
    src_a[5] = 1'b1;
    @(negedge clk);
    src_a[5] = 1'b0;
    to_edge(t + 3);
    chk("edge_before", out_a, 32'h0);
    to_edge(t + 4);
    chk("edge_rise", out_a, 32'h20);
    to_edge(t + 10);
    chk("edge_sticky", out_a, 32'h20);
    bus(ACK, 32'h1, t);
    to_edge(t + 2);
    chk("ack_other", out_a, 32'h20);
    bus(ACK, 32'h20, t);
    chk("ack_t1", out_a, 32'h20);
    to_edge(t + 2);
    chk("ack_t2", out_a, 32'h0);

    @(negedge clk);
    t = n;
    src_a[5] = 1'b1;
    @(negedge clk);
    src_a[5] = 1'b0;
    to_edge(t + 4);
    chk("race_pre", out_a, 32'h20);
    repeat (3) @(negedge clk);
    c = n;
    src_a[5] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr    = 1'b1;
    addr  = ACK;
    wdata = 32'h20;
    @(negedge clk);
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    for (int k = 3; k <= 6; k++) begin
      to_edge(c + k);
      chk("race_set_wins", out_a, 32'h20);
    end
    bus(ACK, 32'h20, t);
    to_edge(t + 2);
    chk("clr_held_high", out_a, 32'h0);
    to_edge(t + 5);
    chk("no_retrigger", out_a, 32'h0);
    @(negedge clk);
    src_a[5] = 1'b0;

    bus(MSK, 32'h1, t);
    repeat (2) @(negedge clk);
    c = n;
    src_b[0] = 1'b1;
    repeat (3) @(negedge clk);
    src_b[0] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      to_edge(c + k);
      chk("glitch_b", out_b, 32'h0);
    end
    @(negedge clk);
    c = n;
    src_b[0] = 1'b1;
    to_edge(c + 7);
    chk("filt_before", out_b, 32'h0);
    to_edge(c + 8);
    chk("filt_rise", out_b, 32'h1);
    @(negedge clk);
    src_b[0] = 1'b0;
    repeat (12) @(negedge clk);

    bus(MSK, 32'h0, t);
    @(negedge clk);
    c = n;
    src_a[0] = 1'b1;
    @(negedge clk);
    src_a[0] = 1'b0;
    to_edge(c + 6);
    chk("masked_edge", out_a, 32'h0);
    bus(MSK, 32'h1, t);
    chk("unmask_t1", out_a, 32'h0);
    to_edge(t + 2);
    chk("unmask_t2", out_a, 32'h1);
    @(negedge clk);
    c = n;
    rst_n = 1'b0;
    to_edge(c + 1);
    chk("midrst_out", out_a, 32'h0);
    chk("midrst_any", 32'(any_a), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus(MSK, 32'h1, t);
    to_edge(t + 2);
    chk("rst_no_pend", out_a, 32'h0);
    to_edge(t + 5);
    chk("rst_no_pend2", out_a, 32'h0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
